// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state width and encodings.
// Display and minutes stages decode the same state values.
package stopwatch_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 2'b00,
      ST_RUNNING = 2'b01,
      ST_PAUSED  = 2'b10
   } sw_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle registered tick while run is high.
// The count holds when run is low, so a partial second survives a pause.
module tick_prescaler #(
   parameter int TICKS_PER_SEC = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic zero,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = $clog2(TICKS_PER_SEC);
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TICKS_PER_SEC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             tick_d, tick_q;

   // Next count and tick; zero overrides counting.
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (zero) begin
         cnt_d  = '0;
         tick_d = 1'b0;
      end else if (run) begin
         if (cnt_q == TERM_CNT) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + CNT_ONE;
            tick_d = 1'b0;
         end
      end else begin
         cnt_d  = cnt_q;
         tick_d = 1'b0;
      end
   end

   // Count and tick registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detection, idle/run/pause FSM, 1 Hz enable
// and clear pulse for the downstream seconds counter.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_btn,
   input  logic       stop_btn,
   input  logic       reset_btn,
   output logic       enable,
   output logic       clear,
   output logic       running,
   output logic [1:0] state
);

   sw_state_e state_d, state_q;
   logic      start_btn_d, start_btn_q;
   logic      stop_btn_d, stop_btn_q;
   logic      reset_btn_d, reset_btn_q;
   logic      clear_d, clear_q;
   logic      running_d, running_q;
   logic      rise_start_s, rise_stop_s, rise_reset_s;
   logic      pre_run_s, pre_zero_s;

   // Rising-edge detect; history resets high so a held button does not fire.
   always_comb begin
      start_btn_d  = start_btn;
      stop_btn_d   = stop_btn;
      reset_btn_d  = reset_btn;
      rise_start_s = start_btn & ~start_btn_q;
      rise_stop_s  = stop_btn  & ~stop_btn_q;
      rise_reset_s = reset_btn & ~reset_btn_q;
   end

   // Next state; reset beats stop, stop beats start.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (rise_start_s) state_d = ST_RUNNING;
            else              state_d = ST_IDLE;
         end
         ST_RUNNING: begin
            if (rise_stop_s) state_d = ST_PAUSED;
            else             state_d = ST_RUNNING;
         end
         ST_PAUSED: begin
            if (rise_start_s) state_d = ST_RUNNING;
            else              state_d = ST_PAUSED;
         end
         default: state_d = ST_IDLE;
      endcase
      if (rise_reset_s) state_d = ST_IDLE;
      else              state_d = state_d;
      clear_d   = rise_reset_s;
      running_d = (state_d == ST_RUNNING);
   end

   // A stop or reset seen on the same edge suppresses counting (and any tick).
   always_comb begin
      pre_zero_s = rise_reset_s;
      pre_run_s  = (state_q == ST_RUNNING) & ~rise_stop_s & ~rise_reset_s;
   end

   // State, button history and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         start_btn_q <= 1'b1;
         stop_btn_q  <= 1'b1;
         reset_btn_q <= 1'b1;
         clear_q     <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         start_btn_q <= start_btn_d;
         stop_btn_q  <= stop_btn_d;
         reset_btn_q <= reset_btn_d;
         clear_q     <= clear_d;
         running_q   <= running_d;
      end
   end

   tick_prescaler #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .zero  (pre_zero_s),
      .run   (pre_run_s),
      .tick  (enable)
   );

   assign clear   = clear_q;
   assign running = running_q;
   assign state   = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICKS_PER_SEC=4: a time-based
// model checked every cycle plus hand-computed literal expectations.
module tb_stopwatch_ctrl;

   localparam int TPS = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_btn = 1'b0;
   logic       stop_btn = 1'b0;
   logic       reset_btn = 1'b0;
   logic       enable, clear, running;
   logic [1:0] state;

   int n_pass = 0;
   int n_total = 0;

   stopwatch_ctrl #(.TICKS_PER_SEC(TPS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_btn (start_btn),
      .stop_btn  (stop_btn),
      .reset_btn (reset_btn),
      .enable    (enable),
      .clear     (clear),
      .running   (running),
      .state     (state)
   );

   always #5 clk = ~clk;

   // Model: 0 idle, 1 running, 2 paused; elapsed = running cycles since last clear
   int   m_state = 0;
   int   elapsed = 0;
   logic m_en = 1'b0;
   logic m_clr = 1'b0;
   logic model_valid = 1'b0;
   logic p_start = 1'b1, p_stop = 1'b1, p_reset = 1'b1;
   logic st, sp, rs, counting;

   assign st = start_btn & ~p_start;
   assign sp = stop_btn & ~p_stop;
   assign rs = reset_btn & ~p_reset;
   assign counting = (m_state == 1) && !sp;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state <= 0;
         elapsed <= 0;
         m_en    <= 1'b0;
         m_clr   <= 1'b0;
         p_start <= 1'b1;
         p_stop  <= 1'b1;
         p_reset <= 1'b1;
         model_valid <= 1'b1;
      end else begin
         model_valid <= 1'b1;
         p_start <= start_btn;
         p_stop  <= stop_btn;
         p_reset <= reset_btn;
         m_clr   <= rs;
         if (rs) begin
            m_state <= 0;
            elapsed <= 0;
            m_en    <= 1'b0;
         end else begin
            m_en <= counting && (((elapsed + 1) % TPS) == 0);
            if (counting) elapsed <= elapsed + 1;
            if (m_state == 1 && sp)      m_state <= 2;
            else if (st && m_state != 1) m_state <= 1;
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Advance one clock and compare every output with the model.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (model_valid) begin
            chk("model_enable",  int'(enable),  int'(m_en));
            chk("model_clear",   int'(clear),   int'(m_clr));
            chk("model_running", int'(running), (m_state == 1) ? 1 : 0);
            chk("model_state",   int'(state),   m_state);
         end
      end
   endtask

   initial begin
      // 1: start held through reset does not fire
      start_btn = 1'b1;
      step(3);
      chk("rst_state", int'(state), 0);
      chk("rst_enable", int'(enable), 0);
      chk("rst_clear", int'(clear), 0);
      chk("rst_running", int'(running), 0);
      rst_n = 1'b1;
      step(3);
      chk("held_start_state", int'(state), 0);
      chk("held_start_enable", int'(enable), 0);
      chk("held_start_clear", int'(clear), 0);
      start_btn = 1'b0;
      step(1);

      // 2: start pulse, ticks every 4 cycles
      start_btn = 1'b1;
      step(1);
      chk("start_state", int'(state), 1);
      chk("start_running", int'(running), 1);
      start_btn = 1'b0;
      step(3);
      chk("tick1_early", int'(enable), 0);
      step(1);
      chk("tick1", int'(enable), 1);
      step(1);
      chk("tick1_one_cycle", int'(enable), 0);
      step(3);
      chk("tick2", int'(enable), 1);
      step(4);
      chk("tick3", int'(enable), 1);

      // 3: pause keeps the partial second
      step(2);
      stop_btn = 1'b1;
      step(1);
      chk("pause_state", int'(state), 2);
      stop_btn = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("paused_no_enable", int'(enable), 0);
      end
      start_btn = 1'b1;
      step(1);
      chk("resume_state", int'(state), 1);
      start_btn = 1'b0;
      step(1);
      chk("resume_plus1", int'(enable), 0);
      step(1);
      chk("resume_tick", int'(enable), 1);

      // 4: stop on the terminal-count edge
      step(3);
      stop_btn = 1'b1;
      step(1);
      chk("tc_stop_state", int'(state), 2);
      chk("tc_stop_no_tick", int'(enable), 0);
      stop_btn = 1'b0;
      step(2);
      start_btn = 1'b1;
      step(1);
      chk("tc_resume_state", int'(state), 1);
      start_btn = 1'b0;
      step(1);
      chk("tc_resume_tick", int'(enable), 1);

      // 5: reset button while running
      step(1);
      reset_btn = 1'b1;
      step(1);
      chk("rb_clear", int'(clear), 1);
      chk("rb_state", int'(state), 0);
      chk("rb_enable", int'(enable), 0);
      step(1);
      chk("rb_clear_one_cycle", int'(clear), 0);
      reset_btn = 1'b0;
      step(1);
      start_btn = 1'b1;
      step(1);
      start_btn = 1'b0;
      step(3);
      chk("rb_restart_early", int'(enable), 0);
      step(1);
      chk("rb_restart_tick", int'(enable), 1);

      // 6: simultaneous rises
      stop_btn = 1'b1;
      step(1);
      stop_btn = 1'b0;
      step(1);
      chk("sim_pre_paused", int'(state), 2);
      start_btn = 1'b1; stop_btn = 1'b1; reset_btn = 1'b1;
      step(1);
      chk("sim_all_state", int'(state), 0);
      chk("sim_all_clear", int'(clear), 1);
      start_btn = 1'b0; stop_btn = 1'b0; reset_btn = 1'b0;
      step(1);
      start_btn = 1'b1;
      step(1);
      start_btn = 1'b0;
      step(1);
      start_btn = 1'b1; stop_btn = 1'b1;
      step(1);
      chk("sim_run_ss_state", int'(state), 2);
      start_btn = 1'b0; stop_btn = 1'b0;
      step(1);
      start_btn = 1'b1; stop_btn = 1'b1;
      step(1);
      chk("sim_pause_ss_state", int'(state), 1);
      start_btn = 1'b0; stop_btn = 1'b0;

      // 7: rst_n mid-second discards the partial count
      step(2);
      rst_n = 1'b0;
      #1;
      chk("async_state", int'(state), 0);
      chk("async_running", int'(running), 0);
      step(2);
      rst_n = 1'b1;
      step(1);
      start_btn = 1'b1;
      step(1);
      start_btn = 1'b0;
      step(3);
      chk("post_rst_early", int'(enable), 0);
      step(1);
      chk("post_rst_tick", int'(enable), 1);
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
